// File: rtl/seq_detect_param_if.sv
// ---------------------------------------------------------------------------
// | Module   : seq_detect_param_if                                          |
// | Desc     : Serial stream, pattern control and match result bundle for   |
// |            the parametrised pattern detector.                           |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               data_in;
  logic               data_valid;
  logic [PAT_LEN-1:0] pattern_in;
  logic               pattern_load;
  logic               overlap_en;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_count;

  // Stream source / controller side
  modport master (
    output data_in, data_valid, pattern_in, pattern_load, overlap_en, cnt_clr,
    input  out, match_count
  );

  // Detector side
  modport slave (
    input  data_in, data_valid, pattern_in, pattern_load, overlap_en, cnt_clr,
    output out, match_count
  );
endinterface

`default_nettype wire

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// | Module   : seq_detect_param                                             |
// | Desc     : Moore serial pattern detector with runtime-loadable pattern, |
// |            overlap/non-overlap selection and saturating match counter.  |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detect_param #(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = 4'b1101,
  parameter int                 CNT_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  seq_detect_param_if.slave det_if
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  // FILLING: history not yet full; ARMED: comparing; MATCH: out asserted
  typedef enum logic [1:0] {
    S_FILLING = 2'd0,
    S_ARMED   = 2'd1,
    S_MATCH   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PAT_LEN-1:0]  pat_q, pat_d;
  logic [PAT_LEN-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [PAT_LEN-1:0]  w_hist_shift;
  logic [FILL_W-1:0]   w_fill_inc;
  logic                w_hit;

  // State register: every piece of detector state, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILLING;
      pat_q   <= RST_PATTERN;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: pattern load beats sampling; a hit drives MATCH and, when
  // not overlapping, flushes history so the next match needs fresh bits
  always_comb begin
    state_d      = S_FILLING;
    pat_d        = pat_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    w_hit        = 1'b0;
    w_hist_shift = {hist_q[PAT_LEN-2:0], det_if.data_in};
    w_fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    if (det_if.pattern_load) begin
      pat_d  = det_if.pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (det_if.data_valid) begin
      hist_d = w_hist_shift;
      fill_d = w_fill_inc;
      if ((w_fill_inc == FILL_FULL) && (w_hist_shift == pat_q)) begin
        w_hit = 1'b1;
        if (!det_if.overlap_en) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end

    // Idle and non-hit edges fall back to a phase chosen by history fill
    if (w_hit) begin
      state_d = S_MATCH;
    end else if (fill_d == FILL_FULL) begin
      state_d = S_ARMED;
    end else begin
      state_d = S_FILLING;
    end
  end

  // Match counter: clear wins over a simultaneous hit; saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (det_if.cnt_clr) begin
      cnt_d = '0;
    end else if (w_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign det_if.out         = (state_q == S_MATCH);
  assign det_if.match_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// | Module   : tb_seq_detect_param                                          |
// | Desc     : Self-checking bench for seq_detect_param; an 8-bit and a     |
// |            2-bit counter instance share one stimulus stream.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       r_d, r_v, r_ld, r_ov, r_clr;
  logic [3:0] r_pin;

  int total = 0;
  int bad   = 0;

  // Reference model: recent valid bits since last flush, oldest first
  bit         mq[$];
  logic [3:0] mpat;
  logic       mout;
  int         mcnt8, mcnt2;

  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) bus8 ();
  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(2)) bus2 ();

  assign bus8.data_in      = r_d;
  assign bus8.data_valid   = r_v;
  assign bus8.pattern_in   = r_pin;
  assign bus8.pattern_load = r_ld;
  assign bus8.overlap_en   = r_ov;
  assign bus8.cnt_clr      = r_clr;
  assign bus2.data_in      = r_d;
  assign bus2.data_valid   = r_v;
  assign bus2.pattern_in   = r_pin;
  assign bus2.pattern_load = r_ld;
  assign bus2.overlap_en   = r_ov;
  assign bus2.cnt_clr      = r_clr;

  seq_detect_param #(.PAT_LEN(4), .RST_PATTERN(4'b1101), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .det_if(bus8.slave)
  );
  seq_detect_param #(.PAT_LEN(4), .RST_PATTERN(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .det_if(bus2.slave)
  );

  wire logic [11:0] w_obs = {bus8.out, bus8.match_count, bus2.out, bus2.match_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_vec();
    return {mout, 8'(mcnt8), mout, 2'(mcnt2)};
  endfunction

  task automatic model_reset();
    mq.delete();
    mpat  = 4'b1101;
    mout  = 1'b0;
    mcnt8 = 0;
    mcnt2 = 0;
  endtask

  // Apply one clock of stimulus, advance the model, land 1 time unit past the edge
  task automatic step(input logic d, input logic v, input logic ld,
                      input logic [3:0] p, input logic ov, input logic clr);
    logic       hit;
    logic [3:0] win;
    r_d = d; r_v = v; r_ld = ld; r_pin = p; r_ov = ov; r_clr = clr;
    hit = 1'b0;
    if (ld) begin
      mpat = p;
      mq.delete();
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() == 4) begin
        win = 4'b0;
        foreach (mq[k]) win = {win[2:0], mq[k]};
        hit = (win == mpat);
      end
      if (hit && !ov) mq.delete();
    end
    mout = hit;
    if (clr) begin
      mcnt8 = 0;
      mcnt2 = 0;
    end else if (hit) begin
      if (mcnt8 < 255) mcnt8++;
      if (mcnt2 < 3) mcnt2++;
    end
    @(posedge clk);
    #1;
    r_d = 1'b0; r_v = 1'b0; r_ld = 1'b0; r_clr = 1'b0;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (w_obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", w_obs, 12'h000);
    end
    sync_reset();
    total++;
    if (w_obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", w_obs, 12'h000);
    end
  endtask

  task automatic test_default();
    logic [3:0] s = 4'b1101;
    sync_reset();
    for (int i = 3; i >= 0; i--) begin
      step(s[i], 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin
        bad++;
        $display("FAIL default_stream bit %0d: got %h want %h", 3 - i, w_obs, exp_vec());
      end
    end
    total++;
    if (bus8.out !== 1'b1 || bus8.match_count !== 8'd1) begin
      bad++;
      $display("FAIL default_match: out=%b cnt=%0d want out=1 cnt=1", bus8.out, bus8.match_count);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    total++;
    if (bus8.out !== 1'b0 || bus8.match_count !== 8'd1) begin
      bad++;
      $display("FAIL default_pulse_end: out=%b cnt=%0d want out=0 cnt=1", bus8.out, bus8.match_count);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1101101;
    for (int ov = 1; ov >= 0; ov--) begin
      sync_reset();
      for (int i = 6; i >= 0; i--) begin
        step(s[i], 1'b1, 1'b0, 4'h0, 1'(ov), 1'b0);
        total++;
        if (w_obs !== exp_vec()) begin
          bad++;
          $display("FAIL overlap%0d bit %0d: got %h want %h", ov, 6 - i, w_obs, exp_vec());
        end
      end
      total++;
      if (bus8.match_count !== ((ov == 1) ? 8'd2 : 8'd1)) begin
        bad++;
        $display("FAIL overlap%0d_count: got %0d want %0d", ov, bus8.match_count, (ov == 1) ? 2 : 1);
      end
    end
  endtask

  task automatic test_gaps();
    logic [6:0] bits  = 7'b1100001;
    logic [6:0] valid = 7'b1100011;
    sync_reset();
    for (int i = 6; i >= 0; i--) begin
      step(bits[i], valid[i], 1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin
        bad++;
        $display("FAIL gaps cyc %0d: got %h want %h", 6 - i, w_obs, exp_vec());
      end
    end
    total++;
    if (bus8.out !== 1'b1) begin
      bad++;
      $display("FAIL gaps_match: out=%b want 1", bus8.out);
    end
  endtask

  task automatic test_load();
    logic [7:0] s = 8'b1101_0110;
    sync_reset();
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step(s[i], 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      total++;
      if (w_obs !== exp_vec()) begin
        bad++;
        $display("FAIL load bit %0d: got %h want %h", 7 - i, w_obs, exp_vec());
      end
    end
    total++;
    if (bus8.out !== 1'b1 || bus8.match_count !== 8'd1) begin
      bad++;
      $display("FAIL load_match: out=%b cnt=%0d want out=1 cnt=1", bus8.out, bus8.match_count);
    end
  endtask

  task automatic test_saturate();
    int highs = 0;
    sync_reset();
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      if (bus2.out === 1'b1) highs++;
      total++;
      if (w_obs !== exp_vec()) begin
        bad++;
        $display("FAIL saturate bit %0d: got %h want %h", i, w_obs, exp_vec());
      end
    end
    total++;
    if (highs != 7 || bus2.match_count !== 2'd3 || bus8.match_count !== 8'd7) begin
      bad++;
      $display("FAIL saturate_totals: highs=%0d cnt2=%0d cnt8=%0d want 7 3 7",
               highs, bus2.match_count, bus8.match_count);
    end
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
    total++;
    if (w_obs !== {1'b1, 8'd0, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL clr_with_hit: got %h want %h", w_obs, {1'b1, 8'd0, 1'b1, 2'd0});
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] s = 4'b0110;
    logic [3:0] t = 4'b1101;
    sync_reset();
    step(1'b0, 1'b0, 1'b1, 4'b0110, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    // drop reset between edges while out is high
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (w_obs !== 12'h000) begin
      bad++;
      $display("FAIL async_reset_out: got %h want %h", w_obs, 12'h000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 3; i >= 1; i--) step(t[i], 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    total++;
    if (w_obs !== 12'h000) begin
      bad++;
      $display("FAIL async_reset_nomatch: got %h want %h", w_obs, 12'h000);
    end
    // reset pattern restored: 1101 completes from the bit already sent
    for (int i = 2; i >= 0; i--) step(t[i], 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    total++;
    if (bus8.out !== 1'b1 || w_obs !== exp_vec()) begin
      bad++;
      $display("FAIL async_reset_pattern: got %h want out=1 %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_random();
    sync_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
      total++;
      if (w_obs !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, w_obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    r_d = 1'b0; r_v = 1'b0; r_ld = 1'b0; r_pin = 4'h0; r_ov = 1'b0; r_clr = 1'b0;
    model_reset();
    test_reset();
    test_default();
    test_overlap();
    test_gaps();
    test_load();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
